// File: rtl/pe_pkg.sv
// Shared types and widths for the sparse-DNN PE scheduler.
// One PE lane multiplies an 8-bit activation by an 8-bit weight into a
// 16-bit signed product; the scheduler sequences vectors through RUN,
// DRAIN and OUT.
package pe_pkg;

  localparam int DATA_W        = 8;
  localparam int PROD_W        = 16;
  localparam int DEF_MFU_COUNT = 9;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    OUT   = 2'd2
  } state_e;

endpackage

// File: rtl/pe_acc_bank.sv
// Bank of per-lane accumulators. Each lane adds its sign-extended 16-bit
// product when enabled; the sum wraps modulo 2^ACC_W. A synchronous clear
// takes priority over accumulation so a result handoff starts the next
// vector from zero.
module pe_acc_bank
  import pe_pkg::*;
#(
  parameter int MFU_COUNT = DEF_MFU_COUNT,
  parameter int ACC_W     = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_clr,
  input  logic                        i_en,
  input  logic [MFU_COUNT*PROD_W-1:0] i_prod,
  output logic [MFU_COUNT*ACC_W-1:0]  o_acc
);

  logic signed [ACC_W-1:0] r_acc [MFU_COUNT];

  // Sign-extend a lane product to accumulator width.
  function automatic logic signed [ACC_W-1:0] sext(input logic signed [PROD_W-1:0] p);
    return ACC_W'(p);
  endfunction

  // Accumulate stage: clear on reset or handoff, otherwise add lane products.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      for (int i = 0; i < MFU_COUNT; i++) begin
        r_acc[i] <= '0;
      end
    end else if (i_en) begin
      for (int i = 0; i < MFU_COUNT; i++) begin
        r_acc[i] <= r_acc[i] + sext(i_prod[i*PROD_W +: PROD_W]);
      end
    end
  end

  // Flatten the lane registers onto the output bus.
  always_comb begin
    o_acc = '0;
    for (int i = 0; i < MFU_COUNT; i++) begin
      o_acc[i*ACC_W +: ACC_W] = r_acc[i];
    end
  end

endmodule

// File: rtl/pe_sparse_sched.sv
// Sequencing controller for one sparse-DNN PE.
// Stage 0 accepts a (value, index) beat and, for nonzero values, launches a
// weight-row read. Stage 1 broadcasts the held activation against the
// returned row and accumulates the PE products. After the last beat the FSM
// drains one cycle and then presents the lane sums until they are taken.
module pe_sparse_sched
  import pe_pkg::*;
#(
  parameter int MFU_COUNT = DEF_MFU_COUNT,
  parameter int IDX_W     = 8,
  parameter int ACC_W     = 24,
  parameter int CNT_W     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        act_valid,
  output logic                        act_ready,
  input  logic [DATA_W-1:0]           act_data,
  input  logic [IDX_W-1:0]            act_idx,
  input  logic                        act_last,
  output logic                        w_rd_en,
  output logic [IDX_W-1:0]            w_addr,
  input  logic [MFU_COUNT*DATA_W-1:0] w_rdata,
  output logic [MFU_COUNT*DATA_W-1:0] pe_a,
  output logic [MFU_COUNT*DATA_W-1:0] pe_w,
  input  logic [MFU_COUNT*PROD_W-1:0] pe_o,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [MFU_COUNT*ACC_W-1:0]  out_data,
  output logic [CNT_W-1:0]            out_nz_cnt
);

  state_e                   r_state;
  logic                     r_act_ready;
  logic                     r_out_valid;
  logic                     r_s1_valid;
  logic signed [DATA_W-1:0] r_s1_act;
  logic [CNT_W-1:0]         r_nz_cnt;

  logic w_accept;
  logic w_nz;
  logic w_fire_out;

  // Saturating increment: the counter sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_accept   = act_valid && r_act_ready;
  assign w_nz       = (act_data != '0);
  assign w_fire_out = r_out_valid && out_ready;

  // Stage 0: launch the weight-row read in the accept cycle, nonzero beats only.
  assign w_rd_en   = w_accept && w_nz;
  assign w_addr    = w_rd_en ? act_idx : '0;
  assign act_ready = r_act_ready;
  assign out_valid = r_out_valid;
  assign out_nz_cnt = r_nz_cnt;

  // Vector sequencing FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_act_ready <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_accept && act_last) begin
            r_state     <= DRAIN;
            r_act_ready <= 1'b0;
          end
        end
        DRAIN: begin
          r_state     <= OUT;
          r_out_valid <= 1'b1;
        end
        OUT: begin
          if (w_fire_out) begin
            r_state     <= RUN;
            r_act_ready <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= RUN;
          r_act_ready <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Stage 0 -> stage 1 boundary: hold the activation while its row is read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_act   <= '0;
    end else begin
      r_s1_valid <= w_accept && w_nz;
      if (w_accept) begin
        r_s1_act <= act_data;
      end
    end
  end

  // Stage 1: drive the PE only while a MAC is in flight.
  always_comb begin
    pe_a = '0;
    pe_w = '0;
    if (r_s1_valid) begin
      pe_a = {MFU_COUNT{r_s1_act}};
      pe_w = w_rdata;
    end
  end

  // Count nonzero MACs in the vector; restarts after each handoff.
  always_ff @(posedge clk) begin
    if (rst || w_fire_out) begin
      r_nz_cnt <= '0;
    end else if (r_s1_valid) begin
      r_nz_cnt <= sat_inc(r_nz_cnt);
    end
  end

  pe_acc_bank #(
    .MFU_COUNT (MFU_COUNT),
    .ACC_W     (ACC_W)
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_fire_out),
    .i_en   (r_s1_valid),
    .i_prod (pe_o),
    .o_acc  (out_data)
  );

endmodule

// File: tb/tb_pe_sparse_sched.sv
// Bench for pe_sparse_sched: two instances (24-bit/8-bit and 16-bit/2-bit
// accumulator/counter widths) share one stimulus stream, a weight memory
// model and a behavioural PE. Expected lane sums are pushed at stimulus time
// and popped by per-instance monitors on each output handshake.
module tb_pe_sparse_sched;

  localparam int MFU   = 9;
  localparam int IDX_W = 8;
  localparam int ACC_A = 24;
  localparam int CNT_A = 8;
  localparam int ACC_B = 16;
  localparam int CNT_B = 2;

  typedef struct packed {
    logic [MFU-1:0][31:0] lane;
    logic [31:0]          nz;
  } exp_t;

  logic clk;
  logic rst;
  logic act_valid;
  logic [7:0] act_data;
  logic [IDX_W-1:0] act_idx;
  logic act_last;
  logic out_ready;

  logic                 act_ready_a, w_rd_en_a, out_valid_a;
  logic [IDX_W-1:0]     w_addr_a;
  logic [MFU*8-1:0]     w_rdata_a, pe_a_a, pe_w_a;
  logic [MFU*16-1:0]    pe_o_a;
  logic [MFU*ACC_A-1:0] out_data_a;
  logic [CNT_A-1:0]     out_nz_a;

  logic                 act_ready_b, w_rd_en_b, out_valid_b;
  logic [IDX_W-1:0]     w_addr_b;
  logic [MFU*8-1:0]     w_rdata_b, pe_a_b, pe_w_b;
  logic [MFU*16-1:0]    pe_o_b;
  logic [MFU*ACC_B-1:0] out_data_b;
  logic [CNT_B-1:0]     out_nz_b;

  logic [MFU*8-1:0] mem [256];

  exp_t q_a[$];
  exp_t q_b[$];
  logic [7:0] bq_d[$];
  logic [7:0] bq_i[$];

  int total = 0;
  int bad = 0;
  int rd_cnt = 0;
  logic [IDX_W-1:0] rd_last = '0;

  pe_sparse_sched #(.MFU_COUNT(MFU), .IDX_W(IDX_W), .ACC_W(ACC_A), .CNT_W(CNT_A)) u_dut_a (
    .clk(clk), .rst(rst), .act_valid(act_valid), .act_ready(act_ready_a),
    .act_data(act_data), .act_idx(act_idx), .act_last(act_last),
    .w_rd_en(w_rd_en_a), .w_addr(w_addr_a), .w_rdata(w_rdata_a),
    .pe_a(pe_a_a), .pe_w(pe_w_a), .pe_o(pe_o_a),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .out_nz_cnt(out_nz_a)
  );

  pe_sparse_sched #(.MFU_COUNT(MFU), .IDX_W(IDX_W), .ACC_W(ACC_B), .CNT_W(CNT_B)) u_dut_b (
    .clk(clk), .rst(rst), .act_valid(act_valid), .act_ready(act_ready_b),
    .act_data(act_data), .act_idx(act_idx), .act_last(act_last),
    .w_rd_en(w_rd_en_b), .w_addr(w_addr_b), .w_rdata(w_rdata_b),
    .pe_a(pe_a_b), .pe_w(pe_w_b), .pe_o(pe_o_b),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .out_nz_cnt(out_nz_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Weight memory: one-cycle read latency per instance.
  always @(posedge clk) begin
    if (w_rd_en_a) w_rdata_a <= mem[w_addr_a];
    if (w_rd_en_b) w_rdata_b <= mem[w_addr_b];
  end

  // Behavioural PE: signed 8x8 -> 16 per lane.
  always_comb begin
    logic signed [15:0] x, y, p;
    pe_o_a = '0;
    pe_o_b = '0;
    for (int i = 0; i < MFU; i++) begin
      x = 16'($signed(pe_a_a[i*8 +: 8]));
      y = 16'($signed(pe_w_a[i*8 +: 8]));
      p = x * y;
      pe_o_a[i*16 +: 16] = p;
      x = 16'($signed(pe_a_b[i*8 +: 8]));
      y = 16'($signed(pe_w_b[i*8 +: 8]));
      p = x * y;
      pe_o_b[i*16 +: 16] = p;
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [MFU*ACC_A-1:0] pack_a(input exp_t e);
    logic [MFU*ACC_A-1:0] v;
    v = '0;
    for (int i = 0; i < MFU; i++) v[i*ACC_A +: ACC_A] = e.lane[i][ACC_A-1:0];
    return v;
  endfunction

  function automatic logic [MFU*ACC_B-1:0] pack_b(input exp_t e);
    logic [MFU*ACC_B-1:0] v;
    v = '0;
    for (int i = 0; i < MFU; i++) v[i*ACC_B +: ACC_B] = e.lane[i][ACC_B-1:0];
    return v;
  endfunction

  // Monitor for the wide instance: pop and compare on every handshake.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid_a && out_ready) begin
      if (q_a.size() == 0) begin
        total++;
        bad++;
        $display("FAIL a_out_unexpected: out_valid with no result pending, required none");
      end else begin
        e = q_a.pop_front();
        chk("a_data", out_data_a, pack_a(e));
        chk("a_nz", out_nz_a, (e.nz > 32'd255) ? 8'hFF : e.nz[7:0]);
      end
    end
  end

  // Monitor for the narrow instance (wrapping sums, 2-bit saturating count).
  always @(negedge clk) begin
    exp_t e;
    if (out_valid_b && out_ready) begin
      if (q_b.size() == 0) begin
        total++;
        bad++;
        $display("FAIL b_out_unexpected: out_valid with no result pending, required none");
      end else begin
        e = q_b.pop_front();
        chk("b_data", out_data_b, pack_b(e));
        chk("b_nz", out_nz_b, (e.nz > 32'd3) ? 2'd3 : e.nz[1:0]);
      end
    end
  end

  // Read-strobe observer.
  always @(negedge clk) begin
    if (w_rd_en_a) begin
      rd_cnt++;
      rd_last = w_addr_a;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_beat(input logic [7:0] d, input logic [7:0] i);
    bq_d.push_back(d);
    bq_i.push_back(i);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_act_ready"}, act_ready_a, 1);
    chk({tag, "_w_rd_en"}, w_rd_en_a, 0);
    chk({tag, "_w_addr"}, w_addr_a, 0);
    chk({tag, "_pe_a"}, pe_a_a, 0);
    chk({tag, "_pe_w"}, pe_w_a, 0);
    chk({tag, "_out_valid"}, out_valid_a, 0);
    chk({tag, "_out_data"}, out_data_a, 0);
    chk({tag, "_nz"}, out_nz_a, 0);
    chk({tag, "_b_out_valid"}, out_valid_b, 0);
  endtask

  // Push the model result, stream the queued beats back to back, check latency.
  task automatic send_vec(input bit backpressure);
    exp_t e;
    int   sum [MFU];
    int   n, nz, a, w;
    n  = bq_d.size();
    nz = 0;
    for (int i = 0; i < MFU; i++) sum[i] = 0;
    for (int b = 0; b < n; b++) begin
      if (bq_d[b] != 8'd0) begin
        nz++;
        a = $signed(bq_d[b]);
        for (int i = 0; i < MFU; i++) begin
          w = $signed(mem[bq_i[b]][i*8 +: 8]);
          sum[i] += a * w;
        end
      end
    end
    e = '0;
    for (int i = 0; i < MFU; i++) e.lane[i] = sum[i];
    e.nz = nz;
    q_a.push_back(e);
    q_b.push_back(e);

    out_ready = !backpressure;
    for (int b = 0; b < n; b++) begin
      act_valid = 1'b1;
      act_data  = bq_d[b];
      act_idx   = bq_i[b];
      act_last  = (b == n - 1);
      chk("beat_ready", act_ready_a, 1);
      tick();
    end
    act_valid = 1'b0;
    act_last  = 1'b0;
    act_data  = '0;
    act_idx   = '0;
    bq_d.delete();
    bq_i.delete();
    chk("lat_c1_valid", out_valid_a, 0);
    tick();
    chk("lat_c2_valid_a", out_valid_a, 1);
    chk("lat_c2_valid_b", out_valid_b, 1);
    if (!backpressure) begin
      tick();
      chk("post_handoff_valid", out_valid_a, 0);
    end
  endtask

  initial begin
    for (int r = 0; r < 256; r++) mem[r] = '0;
    for (int i = 0; i < MFU; i++) begin
      mem[0][i*8 +: 8] = 8'd1;
      mem[1][i*8 +: 8] = 8'd4;
      mem[2][i*8 +: 8] = 8'hFE;
      mem[3][i*8 +: 8] = 8'(i - 4);
      mem[4][i*8 +: 8] = 8'd127;
    end
    w_rdata_a = '0;
    w_rdata_b = '0;
    rst       = 1'b1;
    act_valid = 1'b0;
    act_data  = '0;
    act_idx   = '0;
    act_last  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check_reset("rst");

    // Dense: 2*1 - 1*4 + 3*(-2) = -8 per lane.
    rd_cnt = 0;
    add_beat(8'd2, 8'd0);
    add_beat(8'hFF, 8'd1);
    add_beat(8'd3, 8'd2);
    send_vec(1'b0);
    chk("dense_rd_cnt", rd_cnt, 3);

    // Sparse: only (5,3) is read and multiplied.
    rd_cnt = 0;
    add_beat(8'd0, 8'd5);
    add_beat(8'd5, 8'd3);
    add_beat(8'd0, 8'd7);
    send_vec(1'b0);
    chk("sparse_rd_cnt", rd_cnt, 1);
    chk("sparse_rd_addr", rd_last, 3);

    // Empty vector.
    rd_cnt = 0;
    add_beat(8'd0, 8'd0);
    send_vec(1'b0);
    chk("empty_rd_cnt", rd_cnt, 0);

    // Backpressure: 3*(-2) + 2*4 = 2 per lane, held for five cycles.
    add_beat(8'd3, 8'd2);
    add_beat(8'd2, 8'd1);
    send_vec(1'b1);
    rd_cnt    = 0;
    act_valid = 1'b1;
    act_data  = 8'd9;
    act_idx   = 8'd4;
    repeat (5) begin
      chk("bp_act_ready", act_ready_a, 0);
      chk("bp_out_valid", out_valid_a, 1);
      chk("bp_out_data", out_data_a, pack_a(q_a[0]));
      tick();
    end
    chk("bp_no_read", rd_cnt, 0);
    act_valid = 1'b0;
    act_data  = '0;
    act_idx   = '0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", out_valid_a, 0);

    // Fresh vector after backpressure starts from zero: lanes = i-4.
    add_beat(8'd1, 8'd3);
    send_vec(1'b0);

    // Four 127x127 MACs: 64516 per lane; narrow count saturates at 3.
    for (int k = 0; k < 4; k++) add_beat(8'd127, 8'd4);
    send_vec(1'b0);

    // Five MACs: 80645, wraps to 15109 in the 16-bit instance.
    for (int k = 0; k < 5; k++) add_beat(8'd127, 8'd4);
    send_vec(1'b0);

    // Reset mid-vector after two nonzero beats; partial result discarded.
    act_valid = 1'b1;
    act_data  = 8'd7;
    act_idx   = 8'd0;
    tick();
    act_idx = 8'd1;
    tick();
    act_valid = 1'b0;
    act_data  = '0;
    act_idx   = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("midrst");
    repeat (4) tick();
    chk("midrst_no_out", out_valid_a, 0);

    add_beat(8'd1, 8'd0);
    send_vec(1'b0);

    repeat (2) tick();
    chk("sb_empty_a", q_a.size(), 0);
    chk("sb_empty_b", q_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_sparse_sched.md
Name: pe_sparse_sched

Overview:
Sequencing controller for one sparse-DNN PE, the MFU_COUNT-lane multiplier array with an 8-bit activation and 8-bit weight per lane and a 16-bit product per lane.
- Consumes a compressed activation stream of (value, index) beats and skips zero activations.
- Fetches the weight row addressed by each nonzero activation's index.
- Broadcasts the activation to all lanes and accumulates the per-lane products.
- Emits the MFU_COUNT partial sums through a valid/ready handshake when the vector ends.

Parameters:
- MFU_COUNT, 9, number of PE lanes (3x3 kernel).
- IDX_W, 8, activation index / weight row address width.
- ACC_W, 24, per-lane accumulator width (must be >= 16).
- CNT_W, 8, width of the nonzero-MAC counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- act_valid  in  1  activation beat valid.
- act_ready  out  1  scheduler can accept a beat.
- act_data  in  8  signed activation value.
- act_idx  in  IDX_W  activation index; also the weight row address.
- act_last  in  1  final beat of the vector.
- w_rd_en  out  1  weight memory read strobe.
- w_addr  out  IDX_W  weight row address.
- w_rdata  in  MFU_COUNT*8  weight row, valid one cycle after w_rd_en; lane i in bits [i*8+:8].
- pe_a  out  MFU_COUNT*8  activation to the PE, replicated per lane.
- pe_w  out  MFU_COUNT*8  weights to the PE.
- pe_o  in  MFU_COUNT*16  PE products; combinational from pe_a/pe_w; signed.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumer ready.
- out_data  out  MFU_COUNT*ACC_W  lane sums; lane i in bits [i*ACC_W+:ACC_W].
- out_nz_cnt  out  CNT_W  number of nonzero MACs in the vector.

Behaviour:
- Reset values:
  - state RUN; act_ready 1.
  - w_rd_en 0, w_addr 0.
  - pe_a 0, pe_w 0, s1_valid 0.
  - All accumulators 0; out_valid 0; out_data 0; out_nz_cnt 0.
- FSM states and transitions:
  - RUN: act_ready=1. On the accept cycle with act_last=1, go to DRAIN.
  - DRAIN: act_ready=0. Lasts exactly 1 cycle, then go to OUT.
  - OUT: act_ready=0; out_valid=1; out_data and out_nz_cnt are held stable. On out_valid&&out_ready, clear all accumulators and out_nz_cnt, drop out_valid and return to RUN. RUN accepts beats from the following cycle.
- Stage 0 (accept cycle), when act_valid&&act_ready:
  - If act_data!=0, assert w_rd_en with w_addr=act_idx in the same cycle (combinational).
  - Register act_data into s1_act and set s1_valid=1 at the next edge.
  - If act_data==0, the beat is consumed without a read, MAC or count; act_last still takes effect.
- Stage 1 (cycle after a nonzero accept):
  - pe_a = {MFU_COUNT{s1_act}}; pe_w = w_rdata.
  - At the edge closing this cycle, acc[i] += sign-extended pe_o lane i.
  - out_nz_cnt increments; it saturates at all-ones.
  - When s1_valid=0, pe_a=0, pe_w=0 and the accumulators hold.
- Throughput: one beat per cycle in RUN. Back-to-back nonzero beats fully pipeline with no bubbles.
- Latency: a last beat accepted in cycle c gives out_valid=1 in cycle c+2, with all MACs included.
- Arithmetic:
  - Two's-complement throughout.
  - The accumulator wraps modulo 2^ACC_W; there is no saturation.
- Boundary conditions:
  - Empty vector (a single zero beat with act_last=1): out_data=0 and out_nz_cnt=0 after 2 cycles.
  - act_valid is ignored outside RUN.
  - out_ready while out_valid=0 has no effect.
  - rst mid-vector or in OUT: all state is dropped, the partial result is discarded and no out_valid is produced.

Decomposition:
- Shared package (pe_pkg):
  - DATA_W=8, PROD_W=16, default MFU_COUNT=9.
  - FSM state enum {RUN, DRAIN, OUT}.
- Sub-module pe_acc_bank: MFU_COUNT ACC_W-wide accumulators with lane-wise sign extension, a common enable and a synchronous clear.
- The FSM and pipeline registers stay in pe_sparse_sched.
- The PE itself is instantiated outside this block.

Test Plan:
- Dense 3-beat vector. Beats: (act 2, idx 0), (act -1, idx 1), (act 3, idx 2, last). Memory: row0 all 1, row1 all 4, row2 all -2. Required: every lane = 2-4-6 = -8, out_nz_cnt=3, out_valid in cycle c+2.
- Sparse skip. Beats: (0,5), (5,3), (0,7,last). Required:
  - w_rd_en pulses exactly once, with w_addr=3.
  - Lanes = 5*row3[i].
  - out_nz_cnt=1.
- Empty vector: a single beat (0,0,last). Required: out_data=0, out_nz_cnt=0, and no w_rd_en pulse.
- Output backpressure: hold out_ready=0 for 5 cycles in OUT. Required:
  - act_ready=0 throughout, with act_valid held high.
  - out_data stable.
  - After out_ready=1, a new vector starts with accumulators at 0.
- Wrap and saturation: use ACC_W=16 and CNT_W=2.
  - Feed four beats of 127 x 127. Required: lanes wrap to 64516 mod 65536 = 64516 (0xFC04).
  - Required: out_nz_cnt saturates at 3.
- Reset mid-vector: assert rst after 2 nonzero beats without last. Required:
  - All outputs at reset values.
  - The next vector (1,0,last) with row0 all 1 yields lanes = 1.
